// File: rtl/pixel_sequencer.sv
// Frame sequencer for pixelArray: drives erase/expose/convert/read strobes, generates the
// conversion ramp, captures the four pixel bytes and streams them out over valid/ready.
module pixel_sequencer #(
   parameter int unsigned DW             = 8,
   parameter int unsigned ERASE_CYCLES   = 5,
   parameter int unsigned EXPOSE_CYCLES  = 255,
   parameter int unsigned CONVERT_CYCLES = 255,
   parameter int unsigned READ_CYCLES    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          erase,
   output logic          expose,
   output logic          convert,
   output logic          read12,
   output logic          read34,
   output logic [DW-1:0] adc_data,
   input  logic [DW-1:0] pix_in1,
   input  logic [DW-1:0] pix_in2,
   input  logic [DW-1:0] pix_in3,
   input  logic [DW-1:0] pix_in4,
   output logic [DW-1:0] pix_out,
   output logic          pix_out_valid,
   input  logic          pix_out_ready,
   output logic          busy,
   output logic          frame_done
);

   localparam int unsigned MaxA      = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES
                                                                      : EXPOSE_CYCLES;
   localparam int unsigned MaxB      = (CONVERT_CYCLES > READ_CYCLES) ? CONVERT_CYCLES
                                                                      : READ_CYCLES;
   localparam int unsigned MaxCycles = (MaxA > MaxB) ? MaxA : MaxB;
   // The counter only ever holds (count - 1), so clog2(max) bits are enough.
   localparam int unsigned CW        = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   localparam logic [CW-1:0] EraseLoad   = CW'(ERASE_CYCLES - 1);
   localparam logic [CW-1:0] ExposeLoad  = CW'(EXPOSE_CYCLES - 1);
   localparam logic [CW-1:0] ConvertLoad = CW'(CONVERT_CYCLES - 1);
   localparam logic [CW-1:0] ReadLoad    = CW'(READ_CYCLES - 1);
   localparam logic [DW-1:0] RampMax     = '1;

   typedef enum logic [2:0] {
      StIdle,
      StErase,
      StExpose,
      StConvert,
      StRead12,
      StRead34,
      StDrain
   } state_e;

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_idx, w_idx_nxt;
   logic [DW-1:0] r_buf [4];

   logic          r_erase, r_expose, r_convert, r_read12, r_read34;
   logic          w_erase_nxt, w_expose_nxt, w_convert_nxt, w_read12_nxt, w_read34_nxt;
   logic [DW-1:0] r_adc, w_adc_nxt;
   logic [DW-1:0] r_pix, w_pix_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;

   logic          w_last;
   logic          w_xfer;
   logic          w_cap12;
   logic          w_cap34;

   assign w_last  = (r_cnt == '0);
   assign w_xfer  = (r_state == StDrain) && r_valid && pix_out_ready;
   assign w_cap12 = (r_state == StRead12) && w_last;
   assign w_cap34 = (r_state == StRead34) && w_last;

   // Next-state and phase counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nxt = StErase;
               w_cnt_nxt   = EraseLoad;
            end
         end
         StErase: begin
            if (w_last) begin
               w_state_nxt = StExpose;
               w_cnt_nxt   = ExposeLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StExpose: begin
            if (w_last) begin
               w_state_nxt = StConvert;
               w_cnt_nxt   = ConvertLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StConvert: begin
            if (w_last) begin
               w_state_nxt = StRead12;
               w_cnt_nxt   = ReadLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StRead12: begin
            if (w_last) begin
               w_state_nxt = StRead34;
               w_cnt_nxt   = ReadLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StRead34: begin
            if (w_last) begin
               w_state_nxt = StDrain;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 2'd0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StDrain: begin
            if (w_xfer) begin
               if (r_idx == 2'd3) begin
                  w_state_nxt = StIdle;
                  w_idx_nxt   = 2'd0;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
         end
      endcase
   end

   // Outputs are registered, so they are decoded from the next state.
   always_comb begin
      w_erase_nxt   = (w_state_nxt == StErase);
      w_expose_nxt  = (w_state_nxt == StExpose);
      w_convert_nxt = (w_state_nxt == StConvert);
      w_read12_nxt  = (w_state_nxt == StRead12);
      w_read34_nxt  = (w_state_nxt == StRead34);
      w_busy_nxt    = (w_state_nxt != StIdle);
      w_valid_nxt   = (w_state_nxt == StDrain);
      w_done_nxt    = w_xfer && (r_idx == 2'd3);
      w_adc_nxt     = '0;
      w_pix_nxt     = '0;
      if (w_state_nxt == StConvert && r_state == StConvert) begin
         w_adc_nxt = (r_adc == RampMax) ? RampMax : r_adc + DW'(1);
      end
      if (w_state_nxt == StDrain) begin
         w_pix_nxt = r_buf[w_idx_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_idx     <= 2'd0;
         r_erase   <= 1'b0;
         r_expose  <= 1'b0;
         r_convert <= 1'b0;
         r_read12  <= 1'b0;
         r_read34  <= 1'b0;
         r_adc     <= '0;
         r_pix     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_erase   <= w_erase_nxt;
         r_expose  <= w_expose_nxt;
         r_convert <= w_convert_nxt;
         r_read12  <= w_read12_nxt;
         r_read34  <= w_read34_nxt;
         r_adc     <= w_adc_nxt;
         r_pix     <= w_pix_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         // Only the final read cycle is trusted; earlier bus values are still settling.
         if (w_cap12) begin
            r_buf[0] <= pix_in1;
            r_buf[1] <= pix_in2;
         end
         if (w_cap34) begin
            r_buf[2] <= pix_in3;
            r_buf[3] <= pix_in4;
         end
      end
   end

   assign erase         = r_erase;
   assign expose        = r_expose;
   assign convert       = r_convert;
   assign read12        = r_read12;
   assign read34        = r_read34;
   assign adc_data      = r_adc;
   assign pix_out       = r_pix;
   assign pix_out_valid = r_valid;
   assign busy          = r_busy;
   assign frame_done    = r_done;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer: default-parameter instance for frame, backpressure,
// start filtering, reset and capture checks; a CONVERT_CYCLES=300 instance for ramp saturation.
module tb_pixel_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       erase, expose, convert, read12, read34;
   logic [7:0] adc_data;
   logic [7:0] pix_in1, pix_in2, pix_in3, pix_in4;
   logic [7:0] pix_out;
   logic       pix_out_valid, pix_out_ready, busy, frame_done;

   logic       s_start;
   logic       s_erase, s_expose, s_convert, s_read12, s_read34;
   logic [7:0] s_adc, s_pix_out;
   logic       s_valid, s_ready, s_busy, s_done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pixel_sequencer u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .erase         (erase),
      .expose        (expose),
      .convert       (convert),
      .read12        (read12),
      .read34        (read34),
      .adc_data      (adc_data),
      .pix_in1       (pix_in1),
      .pix_in2       (pix_in2),
      .pix_in3       (pix_in3),
      .pix_in4       (pix_in4),
      .pix_out       (pix_out),
      .pix_out_valid (pix_out_valid),
      .pix_out_ready (pix_out_ready),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   pixel_sequencer #(
      .CONVERT_CYCLES (300)
   ) u_sat (
      .clk           (clk),
      .reset         (reset),
      .start         (s_start),
      .erase         (s_erase),
      .expose        (s_expose),
      .convert       (s_convert),
      .read12        (s_read12),
      .read34        (s_read34),
      .adc_data      (s_adc),
      .pix_in1       (pix_in1),
      .pix_in2       (pix_in2),
      .pix_in3       (pix_in3),
      .pix_in4       (pix_in4),
      .pix_out       (s_pix_out),
      .pix_out_valid (s_valid),
      .pix_out_ready (s_ready),
      .busy          (s_busy),
      .frame_done    (s_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller raises start at the current negedge (cycle 0); this follows the frame until
   // frame_done or the cycle budget runs out.
   task automatic run_frame(input int hold, input int pulse_at, input int bp, input int buschg,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input int exp_last);
      int         n_er, n_ex, n_cv, n_r12, n_r34, n_ovl, n_strb;
      int         ramp_k, nbytes, j, last_c, done_c, r12_i, exp_adc;
      logic [7:0] got [4];
      logic [7:0] tbl [5];
      logic [7:0] held;
      logic [6:0] pat;
      logic       stall, done;
      n_er = 0; n_ex = 0; n_cv = 0; n_r12 = 0; n_r34 = 0; n_ovl = 0;
      ramp_k = 0; nbytes = 0; j = 0; last_c = -1; done_c = -1; r12_i = 0;
      stall = 1'b0; done = 1'b0; held = 8'h00;
      pat = 7'b1101001;
      tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44; tbl[4] = 8'h5A;
      for (int i = 0; i < 4; i++) got[i] = 8'h00;
      if (bp != 0) pix_out_ready = 1'b0;
      for (int c = 1; c <= 1200 && !done; c++) begin
         @(negedge clk);
         if (hold == 0) start = (pulse_at != 0) && (c == pulse_at);
         if (c == 1) check("erase_first_cycle", 32'(erase), 1);
         n_strb = 32'(erase) + 32'(expose) + 32'(convert) + 32'(read12) + 32'(read34);
         if (n_strb > 1) n_ovl++;
         n_er  += 32'(erase);
         n_ex  += 32'(expose);
         n_cv  += 32'(convert);
         n_r12 += 32'(read12);
         n_r34 += 32'(read34);
         exp_adc = convert ? ((ramp_k > 255) ? 255 : ramp_k) : 0;
         check("adc_data", 32'(adc_data), exp_adc);
         if (convert) ramp_k++;
         if (!frame_done) check("busy_in_frame", 32'(busy), 1);
         if (buschg != 0 && read12) begin
            pix_in1 = tbl[(r12_i > 4) ? 4 : r12_i];
            r12_i++;
         end
         if (stall) check("pix_out_hold", 32'(pix_out), 32'(held));
         stall = 1'b0;
         if (pix_out_valid) begin
            if (bp != 0) begin
               pix_out_ready = (j < 7) ? pat[j] : 1'b1;
               j++;
            end
            if (pix_out_ready) begin
               if (nbytes < 4) got[nbytes] = pix_out;
               nbytes++;
               last_c = c;
            end else begin
               stall = 1'b1;
               held  = pix_out;
            end
         end
         if (frame_done) begin
            done   = 1'b1;
            done_c = c;
            check("valid_low_at_done", 32'(pix_out_valid), 0);
            check("busy_low_at_done", 32'(busy), 0);
         end
      end
      check("frame_done_seen", 32'(done), 1);
      check("erase_cycles", n_er, 5);
      check("expose_cycles", n_ex, 255);
      check("convert_cycles", n_cv, 255);
      check("read12_cycles", n_r12, 5);
      check("read34_cycles", n_r34, 5);
      check("strobe_overlap", n_ovl, 0);
      check("byte_count", nbytes, 4);
      check("byte0", 32'(got[0]), 32'(e0));
      check("byte1", 32'(got[1]), 32'(e1));
      check("byte2", 32'(got[2]), 32'(e2));
      check("byte3", 32'(got[3]), 32'(e3));
      check("last_byte_cycle", last_c, exp_last);
      check("done_after_last", done_c, exp_last + 1);
      pix_in1       = 8'h80;
      pix_out_ready = 1'b1;
   endtask

   initial begin
      int  k;
      int  n_sat;
      int  sat_done;
      int  found;
      reset = 1'b1; start = 1'b0; s_start = 1'b0; s_ready = 1'b1; pix_out_ready = 1'b1;
      pix_in1 = 8'h80; pix_in2 = 8'h40; pix_in3 = 8'h20; pix_in4 = 8'h10;
      repeat (2) @(negedge clk);

      // Reset values.
      check("rst_strobes", 32'({erase, expose, convert, read12, read34}), 0);
      check("rst_adc", 32'(adc_data), 0);
      check("rst_pix_out", 32'(pix_out), 0);
      check("rst_valid", 32'(pix_out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);

      // Reset wins over start in the same cycle.
      start = 1'b1;
      @(negedge clk);
      check("rst_prio_erase", 32'(erase), 0);
      check("rst_prio_busy", 32'(busy), 0);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // Basic frame, ready tied high.
      start = 1'b1;
      run_frame(0, 0, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 529);

      // Backpressure 1,0,0,1,0,1,1.
      @(negedge clk);
      start = 1'b1;
      run_frame(0, 0, 1, 0, 8'h80, 8'h40, 8'h20, 8'h10, 532);

      // Start pulse during EXPOSE is dropped; nothing follows the frame.
      @(negedge clk);
      start = 1'b1;
      run_frame(0, 100, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 529);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no_queued_frame", 32'(busy), 0);
      end

      // Held start: second ERASE begins the cycle after frame_done.
      start = 1'b1;
      run_frame(1, 0, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 529);
      run_frame(0, 0, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 529);

      // Settling bus on READ12: only the last-cycle value is captured.
      @(negedge clk);
      start = 1'b1;
      run_frame(0, 0, 0, 1, 8'h5A, 8'h40, 8'h20, 8'h10, 529);

      // Reset at ramp value 100, then a clean frame.
      @(negedge clk);
      start = 1'b1;
      found = 0;
      for (int c = 0; c < 600 && found == 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (convert && adc_data == 8'd100) found = 1;
      end
      check("ramp_reaches_100", found, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_strobes", 32'({erase, expose, convert, read12, read34}), 0);
      check("midrst_adc", 32'(adc_data), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_valid", 32'(pix_out_valid), 0);
      reset = 1'b0;
      start = 1'b1;
      run_frame(0, 0, 0, 0, 8'h80, 8'h40, 8'h20, 8'h10, 529);

      // CONVERT_CYCLES=300: ramp saturates at 255 for the last 45 cycles.
      @(negedge clk);
      s_start = 1'b1;
      k = 0; n_sat = 0; sat_done = 0;
      for (int c = 1; c <= 1200 && sat_done == 0; c++) begin
         @(negedge clk);
         s_start = 1'b0;
         check("sat_adc", 32'(s_adc), s_convert ? ((k > 255) ? 255 : k) : 0);
         if (s_convert) begin
            if (s_adc == 8'hFF) n_sat++;
            k++;
         end
         if (s_done) sat_done = 1;
      end
      check("sat_frame_done", sat_done, 1);
      check("sat_convert_cycles", k, 300);
      check("sat_cycles_at_255", n_sat, 45);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_sequencer.md
Name: pixel_sequencer

Overview:
- Control-and-conversion stage directly upstream of `pixelArray`.
- Runs the pixel frame sequence by driving `erase`, `expose`, `convert`, `read12` and `read34` into the array.
- Generates the digital ADC ramp that the array latches during conversion.
- Captures the four 8-bit pixel values from the array buses during readout, then streams them out over a valid/ready byte interface.

Parameters:
- DW, 8, pixel/ramp data width.
- ERASE_CYCLES, 5, clock cycles `erase` is held high (≥1).
- EXPOSE_CYCLES, 255, clock cycles `expose` is held high (≥1).
- CONVERT_CYCLES, 255, clock cycles `convert` is held high (≥1).
- READ_CYCLES, 5, clock cycles each of `read12`/`read34` is held high (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- erase  out  1  pixel erase strobe to array.
- expose  out  1  exposure enable to array; also gates the anaBias1 model.
- convert  out  1  conversion enable to array; also gates the anaRamp model.
- read12  out  1  array drives pixData1/2 while high.
- read34  out  1  array drives pixData3/4 while high.
- adc_data  out  DW  digital ramp value; tristated onto pixData buses externally when the matching read is low.
- pix_in1..pix_in4  in  DW each  resolved pixData1..4 bus values.
- pix_out  out  DW  streamed pixel byte.
- pix_out_valid  out  1  `pix_out` holds valid data.
- pix_out_ready  in  1  consumer accepts the byte when high together with valid.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the 4th byte is accepted.

Behaviour:
- Interface: one clock, `clk`; reset `reset` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - `erase`, `expose`, `convert`, `read12`, `read34`, `busy`, `pix_out_valid`, `frame_done` = 0.
  - `adc_data` = 0, `pix_out` = 0, capture buffer = 0.
  - State = IDLE, phase counter = 0.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ12, READ34, DRAIN.
- Phase counter: loaded on entry to each timed state; the state lasts exactly its parameter count of cycles, then advances.
- Transitions:
  - IDLE -> ERASE: `start`=1 seen at an edge; `erase` is high from the next cycle.
  - ERASE -> EXPOSE -> CONVERT -> READ12 -> READ34 -> DRAIN, back to back, with no gap cycles.
  - DRAIN -> IDLE after the 4th handshake; `frame_done`=1 for that one cycle.
- Strobe rule: exactly one of `erase`/`expose`/`convert`/`read12`/`read34` is high in its own state; all are low in IDLE and DRAIN. Strobes never overlap.
- Ramp:
  - `adc_data` = k in the k-th CONVERT cycle (0-indexed).
  - Saturates at 2^DW−1 if CONVERT_CYCLES > 2^DW; never wraps.
  - `adc_data` = 0 in all other states.
- Capture:
  - On the last READ12 cycle, `pix_in1` -> buf[0] and `pix_in2` -> buf[1].
  - On the last READ34 cycle, `pix_in3` -> buf[2] and `pix_in4` -> buf[3].
  - No other cycle writes the buffer.
- DRAIN:
  - `pix_out_valid`=1 and `pix_out`=buf[idx], with idx starting at 0.
  - A transfer is `pix_out_valid` & `pix_out_ready` at an edge; idx then increments.
  - `pix_out` must be stable while valid is high and ready is low.
  - Back-to-back ready gives 4 bytes in 4 cycles.
  - After the 4th transfer, valid drops in the same cycle that `frame_done` pulses.
- `busy` = (state != IDLE).
- Boundary cases:
  - `start` outside IDLE is ignored; no queueing.
  - `start` held high continuously starts a new frame on the cycle after the return to IDLE.
  - `pix_out_ready` high outside DRAIN has no effect.
  - Ready low indefinitely stalls DRAIN; no timeout.
  - `reset` mid-operation (any state) returns everything to reset values on the next edge, drops strobes and discards the partial frame.
  - `reset` takes priority over `start` in the same cycle.

Test Plan:
- Basic frame, defaults, ready tied high:
  - Stimulus: 1-cycle `start`; array model returns 0x80/0x40/0x20/0x10.
  - Required: `erase` 5 cycles, `expose` 255, `convert` 255, `read12` 5, `read34` 5.
  - Required: `pix_out` sequence 0x80, 0x40, 0x20, 0x10 on consecutive cycles, then `frame_done` pulse; total 525 + 4 cycles from `start` to last byte.
- Ramp:
  - Check `adc_data` = 0..254 across CONVERT and 0 elsewhere.
  - With CONVERT_CYCLES=300, check saturation at 255 for the last 45 cycles.
- Backpressure:
  - Stimulus: `pix_out_ready` toggled 1,0,0,1,0,1,1.
  - Required: `pix_out` held constant during stalls; exactly 4 transfers in the order buf[0]..buf[3].
- Start filtering:
  - Pulse `start` during EXPOSE -> no effect; one frame only.
  - Hold `start` high -> second ERASE begins the cycle after `frame_done`.
- Reset mid-CONVERT:
  - Stimulus: assert `reset` at ramp value 100.
  - Required: next edge gives all strobes 0, `adc_data`=0, `busy`=0, valid=0.
  - Required: a new `start` gives a clean frame with correct data.
- Bus-change rejection:
  - Stimulus: `pix_in1` changes value on READ12 cycles 1–4, final value 0x5A on the last cycle.
  - Required: captured and streamed byte is 0x5A.
